// File: rtl/dpll_lock_sequencer.sv
// dpll_lock_sequencer: configures the DPLL, releases its reset, waits for lock and retries failed acquisitions
module dpll_lock_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 200000,
  parameter int MAX_RETRIES  = 3,
  parameter int INIT_STEP    = 4,
  parameter int LOSS_FILTER  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_counter,
  input  logic [15:0] cfg_ref_counter,
  input  logic [8:0]  cfg_init,
  input  logic [2:0]  dpll_status,
  output logic        dpll_resetn,
  output logic [15:0] dpll_counter,
  output logic [15:0] dpll_ref_counter,
  output logic [8:0]  dpll_init,
  output logic        busy,
  output logic        locked,
  output logic        fault,
  output logic [1:0]  err_code,
  output logic [1:0]  retry_count,
  output logic        lock_lost
);
  typedef enum logic [2:0] {IDLE, CONFIG, WAIT_LOCK, LOCKED, FAULT} state_t;
  localparam logic [23:0] RC_LAST = 24'(RESET_CYCLES - 1);
  localparam logic [23:0] TO_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] LF_LAST = 24'(LOSS_FILTER - 1);
  localparam logic [1:0]  MAX_R   = 2'(MAX_RETRIES);
  localparam logic [9:0]  STEP    = 10'(INIT_STEP);
  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  retry_q, retry_d, err_q, err_d;
  logic [15:0] sh_cnt_q, sh_cnt_d, sh_ref_q, sh_ref_d;
  logic [8:0]  sh_init_q, sh_init_d, init_sat;
  logic [9:0]  init_sum;
  logic [2:0]  s1_q, s_q;
  logic        resetn_q, busy_q, locked_q, fault_q, lost_q, lost_d, act_d, bad_cfg;
  logic [15:0] dcnt_q, dref_q;
  logic [8:0]  dinit_q;
  logic        unused_tracking;
  assign unused_tracking = s_q[0];
  assign init_sum = {1'b0, sh_init_q} + STEP;
  assign init_sat = init_sum[9] ? 9'h1ff : init_sum[8:0];
  assign bad_cfg  = (cfg_counter == 16'd0) || (cfg_ref_counter == 16'd0);
  assign act_d    = state_d inside {CONFIG, WAIT_LOCK, LOCKED};
  // Next-state: phase progress first, then start re-latches, then stop overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    err_d     = err_q;
    lost_d    = 1'b0;
    sh_cnt_d  = sh_cnt_q;
    sh_ref_d  = sh_ref_q;
    sh_init_d = sh_init_q;
    case (state_q)
      CONFIG: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == RC_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + 24'd1;
        if (s_q[1] || (!s_q[2] && cnt_q == TO_LAST)) begin
          cnt_d = '0;
          if (retry_q == MAX_R) begin
            state_d = FAULT;
            err_d   = s_q[1] ? 2'd3 : 2'd2;
          end else begin
            state_d   = CONFIG;
            retry_d   = retry_q + 2'd1;
            sh_init_d = init_sat;
          end
        end else if (s_q[2]) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        cnt_d = s_q[2] ? '0 : cnt_q + 24'd1;
        if (s_q[1] || (!s_q[2] && cnt_q == LF_LAST)) begin
          state_d = CONFIG;
          cnt_d   = '0;
          retry_d = '0;
          lost_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (start) begin
      sh_cnt_d  = cfg_counter;
      sh_ref_d  = cfg_ref_counter;
      sh_init_d = cfg_init;
      retry_d   = '0;
      cnt_d     = '0;
      err_d     = bad_cfg ? 2'd1 : 2'd0;
      state_d   = bad_cfg ? FAULT : CONFIG;
    end
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      retry_d = '0;
      err_d   = '0;
      lost_d  = 1'b0;
    end
  end
  // State, status synchronizer and registered outputs derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      err_q     <= '0;
      sh_cnt_q  <= '0;
      sh_ref_q  <= '0;
      sh_init_q <= '0;
      s1_q      <= '0;
      s_q       <= '0;
      resetn_q  <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
      lost_q    <= 1'b0;
      dcnt_q    <= '0;
      dref_q    <= '0;
      dinit_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      sh_cnt_q  <= sh_cnt_d;
      sh_ref_q  <= sh_ref_d;
      sh_init_q <= sh_init_d;
      s1_q      <= dpll_status;
      s_q       <= s1_q;
      resetn_q  <= state_d == WAIT_LOCK || state_d == LOCKED;
      busy_q    <= state_d == CONFIG || state_d == WAIT_LOCK;
      locked_q  <= state_d == LOCKED;
      fault_q   <= state_d == FAULT;
      lost_q    <= lost_d;
      dcnt_q    <= act_d ? sh_cnt_d : '0;
      dref_q    <= act_d ? sh_ref_d : '0;
      dinit_q   <= act_d ? sh_init_d : '0;
    end
  end
  assign dpll_resetn      = resetn_q;
  assign dpll_counter     = dcnt_q;
  assign dpll_ref_counter = dref_q;
  assign dpll_init        = dinit_q;
  assign busy             = busy_q;
  assign locked           = locked_q;
  assign fault            = fault_q;
  assign err_code         = err_q;
  assign retry_count      = retry_q;
  assign lock_lost        = lost_q;
endmodule

// File: tb/tb_dpll_lock_sequencer.sv
// tb_dpll_lock_sequencer: directed test-plan scenarios plus random traffic against a behavioural model
module tb_dpll_lock_sequencer;
  localparam int RC = 16, TO = 100, MR = 3, STEP = 4, LF = 4;
  logic clk = 1'b0;
  logic reset, start, stop;
  logic [15:0] cfg_counter, cfg_ref_counter;
  logic [8:0] cfg_init;
  logic [2:0] dpll_status;
  logic dpll_resetn, busy, locked, fault, lock_lost;
  logic [15:0] dpll_counter, dpll_ref_counter;
  logic [8:0] dpll_init;
  logic [1:0] err_code, retry_count;
  int total = 0, bad = 0;
  // model: phase 0 idle, 1 programming/reset, 2 waiting, 3 locked, 4 fault
  int m_ph, m_n, m_try, m_i;
  logic [1:0] m_err;
  logic m_lost;
  logic [15:0] m_c, m_r;
  logic [2:0] d1, d2;
  always #5 clk = ~clk;
  dpll_lock_sequencer #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(TO), .MAX_RETRIES(MR),
                        .INIT_STEP(STEP), .LOSS_FILTER(LF)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_counter(cfg_counter), .cfg_ref_counter(cfg_ref_counter), .cfg_init(cfg_init),
    .dpll_status(dpll_status), .dpll_resetn(dpll_resetn), .dpll_counter(dpll_counter),
    .dpll_ref_counter(dpll_ref_counter), .dpll_init(dpll_init), .busy(busy), .locked(locked),
    .fault(fault), .err_code(err_code), .retry_count(retry_count), .lock_lost(lock_lost)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] gotv();
    return {14'd0, dpll_resetn, dpll_counter, dpll_ref_counter, dpll_init, busy, locked, fault,
            err_code, retry_count, lock_lost};
  endfunction
  function automatic logic [63:0] expv();
    logic act;
    act = m_ph inside {1, 2, 3};
    return {14'd0, m_ph == 2 || m_ph == 3, act ? m_c : 16'd0, act ? m_r : 16'd0,
            act ? 9'(m_i) : 9'd0, m_ph == 1 || m_ph == 2, m_ph == 3, m_ph == 4, m_err,
            2'(m_try), m_lost};
  endfunction
  task automatic model_reset();
    m_ph = 0; m_n = 0; m_try = 0; m_i = 0; m_err = 0; m_lost = 0;
    m_c = 0; m_r = 0; d1 = 0; d2 = 0;
  endtask
  // one clock of behaviour; the decision sees the status driven two clocks earlier
  task automatic model_step();
    logic [2:0] seen;
    int ph0;
    seen = d2; d2 = d1; d1 = dpll_status;
    ph0 = m_ph;
    m_lost = 0;
    case (m_ph)
      1: begin
        m_n++;
        if (m_n == RC) begin m_ph = 2; m_n = 0; end
      end
      2: begin
        m_n++;
        if (seen[1] || (!seen[2] && m_n == TO)) begin
          if (m_try == MR) begin m_ph = 4; m_err = seen[1] ? 2'd3 : 2'd2; end
          else begin m_try++; m_i = (m_i + STEP > 511) ? 511 : m_i + STEP; m_ph = 1; end
          m_n = 0;
        end else if (seen[2]) begin m_ph = 3; m_n = 0; end
      end
      3: begin
        m_n = seen[2] ? 0 : m_n + 1;
        if (seen[1] || m_n == LF) begin m_lost = 1; m_try = 0; m_ph = 1; m_n = 0; end
      end
      default: ;
    endcase
    if (start) begin
      m_c = cfg_counter; m_r = cfg_ref_counter; m_i = int'(cfg_init); m_try = 0; m_n = 0;
      if (cfg_counter == 0 || cfg_ref_counter == 0) begin m_ph = 4; m_err = 1; end
      else begin m_ph = 1; m_err = 0; end
    end
    if (stop && ph0 != 0) begin m_ph = 0; m_n = 0; m_try = 0; m_err = 0; m_lost = 0; end
  endtask
  task automatic tick(logic st = 1'b0, logic sp = 1'b0);
    start = st;
    stop = sp;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("cycle", gotv(), expv());
    start = 1'b0;
    stop = 1'b0;
  endtask
  task automatic wait_resetn(int lim);
    int k = 0;
    while (!dpll_resetn && k < lim) begin tick(); k++; end
    check("resetn_rise", 64'(dpll_resetn), 64'd1);
  endtask
  task automatic wait_locked(int lim);
    int k = 0;
    while (!locked && k < lim) begin tick(); k++; end
    check("lock_wait", 64'(locked), 64'd1);
  endtask
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 check("async_rst", gotv(), 64'd0);
    @(negedge clk);
    check("rst_hold", gotv(), 64'd0);
    reset = 1'b0;
  endtask
  task automatic attempts(output int n, output int inits[$]);
    logic prev;
    int k = 0;
    inits = {};
    while (!fault && k < 700) begin
      prev = dpll_resetn;
      tick();
      if (!prev && dpll_resetn) inits.push_back(int'(dpll_init));
      k++;
    end
    n = inits.size();
    check("fault_reached", 64'(fault), 64'd1);
  endtask
  initial begin
    int low, k, n, pulses;
    int q[$];
    logic st, sp;
    reset = 1'b1; start = 0; stop = 0; cfg_counter = 0; cfg_ref_counter = 0; cfg_init = 0;
    dpll_status = 0;
    model_reset();
    repeat (100) @(negedge clk);
    check("reset_vals", gotv(), 64'd0);
    reset = 1'b0;
    // nominal lock
    cfg_counter = 5000; cfg_ref_counter = 10; cfg_init = 20;
    tick(1);
    low = 0;
    while (busy && !dpll_resetn && low < 40) begin low++; tick(); end
    check("cfg_low_cycles", 64'(low), 64'(RC));
    repeat (50) tick();
    dpll_status = 3'b101;
    k = 0;
    while (!locked && k < 60) begin tick(); k++; end
    check("lock_latency", 64'(k), 64'd3);
    check("err_nominal", 64'(err_code), 64'd0);
    check("counter_out", 64'(dpll_counter), 64'd5000);
    // timeouts with retries, init stepping
    dpll_status = 0;
    tick(1);
    attempts(n, q);
    check("timeout_attempts", 64'(n), 64'd4);
    for (int j = 0; j < 4 && j < n; j++) check("timeout_init", 64'(q[j]), 64'(20 + 4 * j));
    check("timeout_err", 64'(err_code), 64'd2);
    check("timeout_retries", 64'(retry_count), 64'd3);
    // fail beats lock, init saturates
    cfg_init = 510; dpll_status = 3'b110;
    tick(1);
    attempts(n, q);
    check("fail_attempts", 64'(n), 64'd4);
    if (n >= 2) begin
      check("fail_init0", 64'(q[0]), 64'd510);
      check("fail_init1", 64'(q[1]), 64'd511);
    end
    check("fail_err", 64'(err_code), 64'd3);
    // loss-of-lock filter
    cfg_init = 20; dpll_status = 0;
    tick(1);
    wait_resetn(40);
    repeat (5) tick();
    dpll_status = 3'b101;
    wait_locked(20);
    dpll_status = 3'b001;
    repeat (3) tick();
    dpll_status = 3'b101;
    repeat (6) tick();
    check("short_drop_locked", 64'(locked), 64'd1);
    dpll_status = 3'b001;
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 4) dpll_status = 3'b101;
      tick();
      pulses += int'(lock_lost);
    end
    check("lost_pulses", 64'(pulses), 64'd1);
    wait_locked(20);
    // bad config, then stop beating start
    tick(0, 1);
    cfg_ref_counter = 0;
    tick(1);
    check("badcfg_fault", 64'(fault), 64'd1);
    check("badcfg_err", 64'(err_code), 64'd1);
    cfg_ref_counter = 10; dpll_status = 0;
    tick(1);
    wait_resetn(40);
    repeat (5) tick();
    tick(1, 1);
    check("stop_idle", gotv(), 64'd0);
    // asynchronous reset mid-wait
    tick(1);
    wait_resetn(40);
    repeat (57) tick();
    check("in_wait", 64'(busy & dpll_resetn), 64'd1);
    async_reset();
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        k = $urandom_range(0, 9);
        dpll_status = k < 5 ? 3'b101 : k < 8 ? 3'(k & 1) : 3'($urandom);
      end
      st = $urandom_range(0, 59) == 0;
      sp = $urandom_range(0, 79) == 0;
      if (st) begin
        cfg_counter = ($urandom_range(0, 7) == 0 && m_ph inside {0, 4}) ? 16'd0 : 16'($urandom_range(1, 65535));
        cfg_ref_counter = ($urandom_range(0, 7) == 0 && m_ph inside {0, 4}) ? 16'd0 : 16'($urandom_range(1, 65535));
        cfg_init = 9'($urandom);
      end
      if ($urandom_range(0, 999) == 0) async_reset();
      else tick(st, sp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
